key_cond: RTL

- Push-button conditioner sitting directly upstream of the 24-hour clock top level.
- Converts raw board buttons (hour set, minute set, sec/msec clear) into clean set/clear pulses for the time counter.
- Per key: 2-flop synchronisation, debounce on the existing 1 ms clock-enable, one-cycle press pulse, and optional auto-repeat while the key is held.
- Keys are fully independent; one instance serves all three buttons.

---
 rtl/key_cond.sv | 131 +++++++++++++
 1 files changed

// File: rtl/key_cond.sv
// Push-button conditioner for the clock-setting keys: two-flop synchroniser,
// debounce paced by the 1 ms enable, press pulse and optional auto-repeat.
module key_cond #(
    parameter int              NKEY       = 3,
    parameter int              DEB_MS     = 20,
    parameter int              RPT_DLY_MS = 500,
    parameter int              RPT_MS     = 100,
    parameter logic [NKEY-1:0] RPT_MASK   = NKEY'(3'b011)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            CE1,
    input  logic [NKEY-1:0] KEY_IN,
    output logic [NKEY-1:0] KEY_LVL,
    output logic [NKEY-1:0] KEY_PLS
);

    localparam int RPT_MAX = (RPT_DLY_MS > RPT_MS) ? RPT_DLY_MS : RPT_MS;
    localparam int DW      = $clog2(DEB_MS + 1);
    localparam int RW      = $clog2(RPT_MAX + 1);

    // Terminal values are one below the tick count: the terminal tick itself
    // is the one that fires, so the counter never reaches DEB_MS or RPT_*.
    localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_MS - 1);
    localparam logic [RW-1:0] RPT_DLY_LAST = RW'(RPT_DLY_MS - 1);
    localparam logic [RW-1:0] RPT_LAST     = RW'(RPT_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RPT
    } state_t;

    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= KEY_IN;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        state_t        state;
        logic [DW-1:0] deb_cnt;
        logic [RW-1:0] rpt_cnt;
        logic          lvl;
        logic          pls;
        logic          s;
        logic          mismatch;
        logic          accept;
        logic          rpt_tick;

        assign s        = sync2[k];
        assign mismatch = s ^ lvl;
        assign accept   = CE1 && mismatch && (deb_cnt == DEB_LAST);
        // Repeat timing freezes on bouncing-low ticks instead of restarting.
        assign rpt_tick = CE1 && s && RPT_MASK[k];

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                state   <= IDLE;
                deb_cnt <= '0;
                rpt_cnt <= '0;
                lvl     <= 1'b0;
                pls     <= 1'b0;
            end else begin
                pls <= 1'b0;

                if (CE1) begin
                    if (!mismatch || accept) begin
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                    if (accept) begin
                        lvl <= ~lvl;
                    end
                end

                case (state)
                    IDLE: begin
                        if (accept) begin
                            pls     <= 1'b1;
                            rpt_cnt <= '0;
                            state   <= HELD;
                        end
                    end
                    HELD: begin
                        if (accept) begin
                            rpt_cnt <= '0;
                            state   <= IDLE;
                        end else if (rpt_tick) begin
                            if (rpt_cnt == RPT_DLY_LAST) begin
                                pls     <= 1'b1;
                                rpt_cnt <= '0;
                                state   <= RPT;
                            end else begin
                                rpt_cnt <= rpt_cnt + 1'b1;
                            end
                        end
                    end
                    RPT: begin
                        if (accept) begin
                            rpt_cnt <= '0;
                            state   <= IDLE;
                        end else if (rpt_tick) begin
                            if (rpt_cnt == RPT_LAST) begin
                                pls     <= 1'b1;
                                rpt_cnt <= '0;
                            end else begin
                                rpt_cnt <= rpt_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign KEY_LVL[k] = lvl;
        assign KEY_PLS[k] = pls;
    end

endmodule
